// File: rtl/byte_ram_responder_pkg.sv
// Shared types and helpers for the byte-serial data RAM responder.
package byte_ram_responder_pkg;

    // Responder FSM state codes.
    typedef enum logic [1:0] {
        RSP_IDLE   = 2'b00,
        RSP_ACCESS = 2'b01,
        RSP_WAIT   = 2'b10,
        RSP_DONE   = 2'b11
    } rsp_state_e;

    localparam int RAM_SEL_W  = 4;
    localparam int MEM_BYTE_W = 8;

    // Returns {found, lane} for the next set lane in sel. Lane index i maps to
    // byte offset 3-i, so walking offsets upward means walking lane indices
    // downward: pick the highest set lane below ptr, or the highest set lane
    // overall when first is set.
    function automatic logic [2:0] find_next_lane(
        input logic [3:0] sel,
        input logic [1:0] ptr,
        input logic       first
    );
        logic [2:0] res;
        res = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (sel[i] && (first || (i < int'(ptr)))) begin
                res = {1'b1, i[1:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/byte_ram_responder_lane_seq.sv
// Combinational next-set-lane finder used to step through the selected
// byte lanes in ascending byte-offset order, skipping unselected lanes.
module byte_lane_seq
    import byte_ram_responder_pkg::*;
(
    input  logic [3:0] sel,
    input  logic [1:0] ptr,
    input  logic       first,
    output logic [1:0] next_ptr,
    output logic       none_left
);

    logic [2:0] lane_s;

    // Pick the next lane and flag when no selected lane remains.
    always_comb begin
        lane_s    = find_next_lane(sel, ptr, first);
        next_ptr  = lane_s[1:0];
        none_left = ~lane_s[2];
    end

endmodule

// File: rtl/byte_ram_responder.sv
// Data-bus responder: serves 32-bit byte-lane-selected loads/stores from a
// byte-wide synchronous RAM, one byte per RAM access, stalling the CPU
// while a request is in progress.
module byte_ram_responder
    import byte_ram_responder_pkg::*;
#(
    parameter int MEM_AW = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [3:0]        sel,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              stallreq,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

    rsp_state_e        state_r;
    logic              we_r;
    logic [MEM_AW-3:0] addr_r;
    logic [3:0]        sel_r;
    logic [31:0]       data_r;
    logic [1:0]        ptr_r;
    logic [1:0]        cnt_r;
    logic [31:0]       data_o_r;
    logic              mem_ce_r;
    logic              mem_we_r;
    logic [MEM_AW-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r;

    logic              idle_s;
    logic [3:0]        seq_sel_s;
    logic [1:0]        nxt_ptr_s;
    logic              none_left_s;
    logic [MEM_AW-3:0] base_s;
    logic [31:0]       word_s;
    logic              we_s;
    logic [MEM_AW-1:0] nxt_addr_s;
    logic [7:0]        nxt_wdata_s;
    logic              unused_addr_s;

    // Word-aligned addressing: the low two bits and bits above the RAM are dropped.
    assign unused_addr_s = ^{addr[31:MEM_AW], addr[1:0]};

    // In IDLE the lane search and next-access fields come from the live
    // request (it is being accepted this cycle); afterwards from the latches.
    always_comb begin
        idle_s = (state_r == RSP_IDLE);
        if (idle_s) begin
            seq_sel_s = sel;
            base_s    = addr[MEM_AW-1:2];
            word_s    = data_i;
            we_s      = we;
        end else begin
            seq_sel_s = sel_r;
            base_s    = addr_r;
            word_s    = data_r;
            we_s      = we_r;
        end
        nxt_addr_s  = {base_s, 2'd3 - nxt_ptr_s};
        nxt_wdata_s = word_s[{nxt_ptr_s, 3'b000} +: 8];
    end

    byte_lane_seq u_lane_seq (
        .sel       (seq_sel_s),
        .ptr       (ptr_r),
        .first     (idle_s),
        .next_ptr  (nxt_ptr_s),
        .none_left (none_left_s)
    );

    // Request FSM with registered RAM strobes and load-data assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= RSP_IDLE;
            we_r        <= 1'b0;
            addr_r      <= '0;
            sel_r       <= 4'b0000;
            data_r      <= 32'h0000_0000;
            ptr_r       <= 2'd0;
            cnt_r       <= 2'd0;
            data_o_r    <= 32'h0000_0000;
            mem_ce_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 8'h00;
        end else begin
            case (state_r)
                RSP_IDLE: begin
                    if (ce && (sel != 4'b0000)) begin
                        we_r        <= we;
                        addr_r      <= addr[MEM_AW-1:2];
                        sel_r       <= sel;
                        data_r      <= data_i;
                        data_o_r    <= 32'h0000_0000;
                        ptr_r       <= nxt_ptr_s;
                        mem_ce_r    <= 1'b1;
                        mem_we_r    <= we_s;
                        mem_addr_r  <= nxt_addr_s;
                        mem_wdata_r <= we_s ? nxt_wdata_s : mem_wdata_r;
                        state_r     <= RSP_ACCESS;
                    end else begin
                        mem_ce_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        state_r  <= RSP_IDLE;
                    end
                end
                RSP_ACCESS: begin
                    if (!we_r) begin
                        mem_ce_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        cnt_r    <= RD_LAT_C;
                        state_r  <= RSP_WAIT;
                    end else if (!none_left_s) begin
                        ptr_r       <= nxt_ptr_s;
                        mem_ce_r    <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= nxt_addr_s;
                        mem_wdata_r <= nxt_wdata_s;
                        state_r     <= RSP_ACCESS;
                    end else begin
                        mem_ce_r <= 1'b0;
                        mem_we_r <= 1'b0;
                        state_r  <= RSP_DONE;
                    end
                end
                RSP_WAIT: begin
                    if (cnt_r == 2'd1) begin
                        data_o_r[{ptr_r, 3'b000} +: 8] <= mem_rdata;
                        if (!none_left_s) begin
                            ptr_r      <= nxt_ptr_s;
                            mem_ce_r   <= 1'b1;
                            mem_we_r   <= 1'b0;
                            mem_addr_r <= nxt_addr_s;
                            state_r    <= RSP_ACCESS;
                        end else begin
                            state_r <= RSP_DONE;
                        end
                    end else begin
                        cnt_r   <= cnt_r - 2'd1;
                        state_r <= RSP_WAIT;
                    end
                end
                RSP_DONE: begin
                    // The ce seen here still belongs to the finished request.
                    mem_ce_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    state_r  <= RSP_IDLE;
                end
                default: begin
                    mem_ce_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    state_r  <= RSP_IDLE;
                end
            endcase
        end
    end

    // Stall covers the accept cycle (combinational) and every ACCESS/WAIT cycle.
    always_comb begin
        if ((state_r == RSP_ACCESS) || (state_r == RSP_WAIT)) begin
            stallreq = 1'b1;
        end else if (idle_s && rst && ce && (sel != 4'b0000)) begin
            stallreq = 1'b1;
        end else begin
            stallreq = 1'b0;
        end
    end

    assign data_o    = data_o_r;
    assign mem_ce    = mem_ce_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_byte_ram_responder.sv
// Self-checking bench for byte_ram_responder: byte RAM model with read
// latency, CPU model that honours stallreq, scoreboard of expected results.
module tb_byte_ram_responder;

    localparam int MEM_AW = 17;
    localparam int RD_LAT = 1;

    typedef struct {
        logic [31:0] data;
        int          stall;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ce = 1'b0;
    logic              we = 1'b0;
    logic [31:0]       addr = 32'h0;
    logic [3:0]        sel = 4'h0;
    logic [31:0]       data_i = 32'h0;
    logic [31:0]       data_o;
    logic              stallreq;
    logic              mem_ce;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    logic [7:0]        ram [0:(1<<MEM_AW)-1];
    logic [7:0]        rd_pipe [0:RD_LAT-1];
    logic [MEM_AW+8:0] acc_q [$];
    exp_t              exp_q [$];
    int                n_tests = 0;
    int                n_fail = 0;

    byte_ram_responder #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .we        (we),
        .addr      (addr),
        .sel       (sel),
        .data_i    (data_i),
        .data_o    (data_o),
        .stallreq  (stallreq),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Backing RAM: synchronous write, read data valid RD_LAT cycles after mem_ce.
    assign mem_rdata = rd_pipe[RD_LAT-1];
    always @(posedge clk) begin
        if (mem_ce === 1'b1) begin
            if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
            else rd_pipe[0] <= ram[mem_addr];
        end
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Log every RAM access as {we, addr, wdata}.
    always @(negedge clk) begin
        if (mem_ce === 1'b1) acc_q.push_back({mem_we, mem_addr, mem_wdata});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycle();
        ce = 1'b0;
        @(negedge clk); #1;
    endtask

    // One CPU request; ends #1 after the negedge of the DONE cycle.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic [31:0] exp_d, input int exp_stall,
                          input logic hold, input logic from_done, input string name);
        exp_t e;
        int   stall_cnt;
        exp_q.push_back('{data: exp_d, stall: exp_stall});
        ce = 1'b1; we = w; addr = a; sel = s; data_i = d;
        #1;
        if (from_done) begin
            n_tests++;
            if (stallreq !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_done_ignores_ce: stallreq got %b required 0", name, stallreq);
            end
            @(negedge clk); #1;
        end
        stall_cnt = 0;
        while (stallreq === 1'b1 && stall_cnt < 100) begin
            stall_cnt++;
            @(negedge clk); #1;
        end
        e = exp_q.pop_front();
        n_tests++;
        if (stall_cnt !== e.stall) begin
            n_fail++;
            $display("FAIL %s_stall: got %0d cycles required %0d", name, stall_cnt, e.stall);
        end
        n_tests++;
        if (data_o !== e.data) begin
            n_fail++;
            $display("FAIL %s_data: got %h required %h", name, data_o, e.data);
        end
        if (!hold) ce = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({data_o, stallreq, mem_ce, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data_o=%h stall=%b ce=%b we=%b addr=%h wd=%h required all 0",
                     data_o, stallreq, mem_ce, mem_we, mem_addr, mem_wdata);
        end
        rst = 1'b1;
        idle_cycle();
    endtask

    task automatic test_full_store();
        logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        idle_cycle();
        acc_q.delete();
        do_req(1'b1, 32'h10, 4'hF, 32'h1122_3344, 32'h0, 5, 1'b0, 1'b0, "store_word");
        n_tests++;
        if (acc_q.size() !== 4) begin
            n_fail++;
            $display("FAIL store_word_count: got %0d accesses required 4", acc_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (acc_q[i] !== {1'b1, 17'(32'h10 + i), bytes[i]}) begin
                    n_fail++;
                    $display("FAIL store_word_acc%0d: got %h required %h", i, acc_q[i],
                             {1'b1, 17'(32'h10 + i), bytes[i]});
                end
            end
        end
    endtask

    task automatic test_full_load();
        idle_cycle();
        acc_q.delete();
        do_req(1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h1122_3344, 9, 1'b0, 1'b0, "load_word");
        n_tests++;
        if (acc_q.size() !== 4) begin
            n_fail++;
            $display("FAIL load_word_count: got %0d accesses required 4", acc_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (acc_q[i][MEM_AW+8:8] !== {1'b0, 17'(32'h10 + i)}) begin
                    n_fail++;
                    $display("FAIL load_word_acc%0d: got %h required %h", i, acc_q[i][MEM_AW+8:8],
                             {1'b0, 17'(32'h10 + i)});
                end
            end
        end
    endtask

    task automatic test_byte();
        idle_cycle();
        acc_q.delete();
        do_req(1'b1, 32'h13, 4'b0010, 32'h0000_AB00, 32'h0, 2, 1'b0, 1'b0, "store_byte");
        n_tests++;
        if (acc_q.size() !== 1 || acc_q[0] !== {1'b1, 17'h12, 8'hAB}) begin
            n_fail++;
            $display("FAIL store_byte_acc: got %0d accesses first %h required 1 access %h",
                     acc_q.size(), acc_q.size() > 0 ? acc_q[0] : '0, {1'b1, 17'h12, 8'hAB});
        end
        idle_cycle();
        acc_q.delete();
        do_req(1'b0, 32'h12, 4'b0010, 32'hFFFF_FFFF, 32'h0000_AB00, 3, 1'b0, 1'b0, "load_byte");
        n_tests++;
        if (acc_q.size() !== 1 || acc_q[0][MEM_AW+8:8] !== {1'b0, 17'h12}) begin
            n_fail++;
            $display("FAIL load_byte_acc: got %0d accesses required 1 read at 12", acc_q.size());
        end
    endtask

    task automatic test_sparse();
        idle_cycle();
        do_req(1'b1, 32'h20, 4'hF, 32'h5566_7788, 32'h0, 5, 1'b0, 1'b0, "prefill");
        idle_cycle();
        acc_q.delete();
        do_req(1'b1, 32'h20, 4'b1001, 32'hA0B0_C0D0, 32'h0, 3, 1'b0, 1'b0, "sparse_store");
        n_tests++;
        if (acc_q.size() !== 2 || acc_q[0] !== {1'b1, 17'h20, 8'hA0} || acc_q[1] !== {1'b1, 17'h23, 8'hD0}) begin
            n_fail++;
            $display("FAIL sparse_store_acc: got %0d accesses required writes A0@20 D0@23 only", acc_q.size());
        end
        idle_cycle();
        do_req(1'b0, 32'h20, 4'hF, 32'h0, 32'hA066_77D0, 9, 1'b0, 1'b0, "sparse_readback");
    endtask

    task automatic test_back_to_back();
        idle_cycle();
        acc_q.delete();
        do_req(1'b1, 32'h40, 4'hF, 32'hCAFE_F00D, 32'h0, 5, 1'b1, 1'b0, "b2b_store");
        do_req(1'b0, 32'h40, 4'hF, 32'h0, 32'hCAFE_F00D, 9, 1'b0, 1'b1, "b2b_load");
        n_tests++;
        if (acc_q.size() !== 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d accesses required 8", acc_q.size());
        end
    endtask

    task automatic test_reset_mid();
        idle_cycle();
        ce = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF; data_i = 32'h0;
        #1;
        repeat (4) begin
            @(negedge clk); #1;
        end
        n_tests++;
        if (stallreq !== 1'b1 || data_o !== 32'h1100_0000) begin
            n_fail++;
            $display("FAIL midload_state: got stall=%b data_o=%h required 1 11000000", stallreq, data_o);
        end
        rst = 1'b0;
        ce = 1'b0;
        #1;
        n_tests++;
        if ({data_o, stallreq, mem_ce, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL midload_reset: got data_o=%h stall=%b ce=%b addr=%h required all 0",
                     data_o, stallreq, mem_ce, mem_addr);
        end
        @(negedge clk); #1;
        rst = 1'b1;
        acc_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_tests++;
            if (stallreq !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle%0d: stallreq got %b required 0", i, stallreq);
            end
        end
        n_tests++;
        if (acc_q.size() !== 0) begin
            n_fail++;
            $display("FAIL post_reset_noacc: got %0d accesses required 0", acc_q.size());
        end
        do_req(1'b0, 32'h10, 4'hF, 32'h0, 32'h1122_AB44, 9, 1'b0, 1'b0, "post_reset_load");
        idle_cycle();
        acc_q.delete();
        do_req(1'b1, 32'h10, 4'h0, 32'h9999_9999, 32'h1122_AB44, 0, 1'b1, 1'b0, "sel_zero");
        repeat (2) begin
            @(negedge clk); #1;
        end
        n_tests++;
        if (stallreq !== 1'b0 || data_o !== 32'h1122_AB44 || acc_q.size() !== 0) begin
            n_fail++;
            $display("FAIL sel_zero_noop: got stall=%b data_o=%h acc=%0d required 0 1122ab44 0",
                     stallreq, data_o, acc_q.size());
        end
        ce = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_store();
        test_full_load();
        test_byte();
        test_sparse();
        test_back_to_back();
        test_reset_mid();
        idle_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
